tmr_event_detect: RTL and testbench
===================================

# tmr_event_detect

Parametrised timer event detector. Watches the counter value across consecutive PCLK cycles and raises sticky overflow, underflow and compare-match flags, each with its own interrupt enable, plus a combined interrupt. Sits between the timer counter and the APB register block: flags feed the status register, clear strobes come back from status-register write-1-to-clear decoding. Generalises the 8-bit overflow/underflow comparator to any counter width and adds compare-match, per-flag clear and interrupt generation.

## Interface
- CNT_WIDTH, 8, counter width in bits; legal range 2..32.
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cnt_en  in  1  timer running; detection is enabled only while high.
- cnt_down  in  1  count direction: 1 = down, 0 = up.
- cnt_load  in  1  counter was software-loaded in the current cycle; suppresses detection for this cycle.
- cnt_value  in  CNT_WIDTH  current counter value.
- cmp_value  in  CNT_WIDTH  compare register.
- flag_clr  in  3  clear strobes, one cycle wide: [0] ovf, [1] udf, [2] cmp.
- irq_en  in  3  interrupt enables, same bit order as flag_clr.
- tmr_ovf  out  1  sticky overflow flag.
- tmr_udf  out  1  sticky underflow flag.
- tmr_cmp  out  1  sticky compare-match flag.
- tmr_irq  out  1  OR of (flags & irq_en).

## Operation
- prev register: loads cnt_value every cycle. prev_vld register: set after the first post-reset cycle; cleared by reset.
- MAX = all ones at CNT_WIDTH. All compares are unsigned at CNT_WIDTH with no width extension.
- An event is qualified only when prev_vld = 1, cnt_en = 1 and cnt_load = 0.
- Overflow event: qualified, cnt_down = 0, prev == MAX and cnt_value == 0.
- Underflow event: qualified, cnt_down = 1, prev == 0 and cnt_value == MAX.
- Compare event: qualified, cnt_value == cmp_value and prev != cmp_value, so it fires on entry only. A counter held at the compare value fires once.
- Each flag is a two-state sticky bit (IDLE → SET on event, SET → IDLE on clear). Event and clear in the same cycle: set wins and the flag stays 1.
- A non-wrapping jump (e.g. MAX → 5) is not an overflow.
- Changing cnt_down while running does not by itself create an event.
- tmr_irq = |({tmr_cmp, tmr_udf, tmr_ovf} & irq_en). It is combinational from registered flags.

## Timing
- Reset values: tmr_ovf = 0, tmr_udf = 0, tmr_cmp = 0, tmr_irq = 0, prev = 0, prev_vld = 0.
- Latency: a flag rises at the first PCLK edge after the cycle in which the wrapped or matching cnt_value is presented, i.e. 1 cycle.
- tmr_irq follows a flag in the same cycle. It follows an irq_en change with zero cycles latency.
- A flag_clr pulse drops the flag at the next edge.
- Reset asserted mid-operation clears all flags immediately (asynchronous). The first cycle after release never produces an event, because prev_vld = 0.
- While cnt_en = 0, prev keeps tracking, so no spurious event occurs on re-enable.

## Configuration
- TMR_CMP_EN defined: compare-match logic, tmr_cmp and irq_en[2] are functional.
- TMR_CMP_EN undefined: the compare comparator is not built. tmr_cmp is tied to 0, cmp_value, flag_clr[2] and irq_en[2] are ignored, and tmr_irq covers ovf/udf only. The port list is unchanged.

## Structure
- Package tmr_pkg holds:
  - flag index constants TMR_FLG_OVF = 0, TMR_FLG_UDF = 1, TMR_FLG_CMP = 2;
  - TMR_NFLG = 3;
  - the flag-vector typedef, shared with the register block.
- Sub-module tmr_flag_sticky: one sticky flag with set-over-clear priority and async reset. Instantiated once per flag.

## Test plan
- CNT_WIDTH = 8, up count, cnt_value FE → FF → 00 → tmr_ovf = 1 one cycle after 00 appears. With irq_en = 001, tmr_irq = 1.
- Down count, 01 → 00 → FF → tmr_udf = 1. Then cnt_load = 1 with a jump 00 → FF → no event. Then a jump FF → 00 in up mode with cnt_en = 0 → no event.
- cmp_value = 0x40, counter 3F → 40 held for 5 cycles → tmr_cmp set once. Then flag_clr[2] → flag drops next edge and does not reassert while the counter holds at 40.
- Overflow event and flag_clr[0] in the same cycle → tmr_ovf = 1 after the edge.
- PRESETn asserted with all flags set → all outputs 0 immediately. On release with cnt_value = 00 and prev = FF history → no event.
- CNT_WIDTH = 16: FFFF → 0000 sets ovf. Build without TMR_CMP_EN → tmr_cmp stays 0 on a match.

Source files
------------

// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared flag indices, flag vector type and sticky-flag state encoding
package tmr_pkg;

    localparam int TMR_NFLG    = 3;
    localparam int TMR_FLG_OVF = 0;
    localparam int TMR_FLG_UDF = 1;
    localparam int TMR_FLG_CMP = 2;

    // One bit per flag, indexed by TMR_FLG_*; also used by the register block
    typedef logic [TMR_NFLG-1:0] tmr_flg_t;

    typedef enum logic {
        FLG_IDLE = 1'b0,
        FLG_SET  = 1'b1
    } tmr_flg_state_e;

endpackage

// File: rtl/tmr_event_detect_if.sv
// rtl/tmr_event_detect_if.sv - counter/flag signal bundle between timer counter, detector and register block
// Signals:
//   cnt_en, cnt_down, cnt_load, cnt_value, cmp_value  counter state into the detector
//   flag_clr, irq_en                                  status-register clear strobes and interrupt enables
//   tmr_ovf, tmr_udf, tmr_cmp, tmr_irq                sticky flags and combined interrupt out of the detector
// Modports: master = counter/register side, slave = detector.
interface tmr_event_detect_if
    import tmr_pkg::*;
#(
    parameter int CNT_WIDTH = 8
);
    logic                 cnt_en;
    logic                 cnt_down;
    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_value;
    logic [CNT_WIDTH-1:0] cmp_value;
    tmr_flg_t             flag_clr;
    tmr_flg_t             irq_en;
    logic                 tmr_ovf;
    logic                 tmr_udf;
    logic                 tmr_cmp;
    logic                 tmr_irq;

    modport master (
        output cnt_en, cnt_down, cnt_load, cnt_value, cmp_value, flag_clr, irq_en,
        input  tmr_ovf, tmr_udf, tmr_cmp, tmr_irq
    );

    modport slave (
        input  cnt_en, cnt_down, cnt_load, cnt_value, cmp_value, flag_clr, irq_en,
        output tmr_ovf, tmr_udf, tmr_cmp, tmr_irq
    );

endinterface

// File: rtl/tmr_flag_sticky.sv
// rtl/tmr_flag_sticky.sv - one sticky status flag, set wins over clear
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   set_i    event strobe
//   clr_i    clear strobe
//   flag_o   registered flag
module tmr_flag_sticky
    import tmr_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    tmr_flg_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FLG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FLG_IDLE: if (set_i) state_d = FLG_SET;
            // A new event arriving with the clear keeps the flag up so it is not lost
            FLG_SET:  if (clr_i && !set_i) state_d = FLG_IDLE;
            default:  state_d = FLG_IDLE;
        endcase
    end

    assign flag_o = (state_q == FLG_SET);

endmodule

// File: rtl/tmr_event_detect.sv
// rtl/tmr_event_detect.sv - timer overflow/underflow/compare-match detector with sticky flags and interrupt
// Ports:
//   PCLK     clock
//   PRESETn  asynchronous active-low reset
//   bus      tmr_event_detect_if.slave: counter state, clear strobes, irq enables in; flags and irq out
// Build option: TMR_CMP_EN builds the compare-match logic; otherwise tmr_cmp is 0 and
// cmp_value, flag_clr[2], irq_en[2] are ignored.
module tmr_event_detect
    import tmr_pkg::*;
#(
    parameter int CNT_WIDTH = 8
)(
    input  logic              PCLK,
    input  logic              PRESETn,
    tmr_event_detect_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    logic [CNT_WIDTH-1:0] prev_q, prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic                 qual;
    tmr_flg_t             evt;
    tmr_flg_t             clr_eff;
    tmr_flg_t             irq_en_eff;
    tmr_flg_t             flags;

    // prev keeps tracking even while the timer is stopped so re-enable cannot see a stale wrap
    always_comb begin
        prev_d     = bus.cnt_value;
        prev_vld_d = 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign qual = prev_vld_q && bus.cnt_en && !bus.cnt_load;

    always_comb begin
        evt        = '0;
        clr_eff    = bus.flag_clr;
        irq_en_eff = bus.irq_en;
        // Only a true wrap counts; a direct jump such as MAX -> 5 does not
        evt[TMR_FLG_OVF] = qual && !bus.cnt_down && (prev_q == CNT_MAX) && (bus.cnt_value == CNT_ZERO);
        evt[TMR_FLG_UDF] = qual &&  bus.cnt_down && (prev_q == CNT_ZERO) && (bus.cnt_value == CNT_MAX);
`ifdef TMR_CMP_EN
        // Entry-only match: a counter parked on the compare value fires once
        evt[TMR_FLG_CMP] = qual && (bus.cnt_value == bus.cmp_value) && (prev_q != bus.cmp_value);
`else
        clr_eff[TMR_FLG_CMP]    = 1'b0;
        irq_en_eff[TMR_FLG_CMP] = 1'b0;
`endif
    end

`ifndef TMR_CMP_EN
    logic unused_cmp;
    assign unused_cmp = ^{bus.cmp_value, bus.flag_clr[TMR_FLG_CMP], bus.irq_en[TMR_FLG_CMP]};
`endif

    for (genvar i = 0; i < TMR_NFLG; i++) begin : g_flag
        tmr_flag_sticky u_flag (
            .clk_i   (PCLK),
            .rst_n_i (PRESETn),
            .set_i   (evt[i]),
            .clr_i   (clr_eff[i]),
            .flag_o  (flags[i])
        );
    end

    assign bus.tmr_ovf = flags[TMR_FLG_OVF];
    assign bus.tmr_udf = flags[TMR_FLG_UDF];
`ifdef TMR_CMP_EN
    assign bus.tmr_cmp = flags[TMR_FLG_CMP];
`else
    assign bus.tmr_cmp = 1'b0;
`endif
    assign bus.tmr_irq = |(flags & irq_en_eff);

endmodule

// File: tb/tb_tmr_event_detect.sv
// tb/tb_tmr_event_detect.sv - self-checking bench for tmr_event_detect (8-bit and 16-bit instances)
module tb_tmr_event_detect;

`ifdef TMR_CMP_EN
    localparam bit CMP_BUILT = 1'b1;
`else
    localparam bit CMP_BUILT = 1'b0;
`endif
    localparam logic [2:0] FLG_MASK = CMP_BUILT ? 3'b111 : 3'b011;

    logic PCLK  = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 PCLK = ~PCLK;

    tmr_event_detect_if #(.CNT_WIDTH(8))  b8 ();
    tmr_event_detect_if #(.CNT_WIDTH(16)) b16 ();

    tmr_event_detect #(.CNT_WIDTH(8))  u_dut8  (.PCLK(PCLK), .PRESETn(rst_n), .bus(b8.slave));
    tmr_event_detect #(.CNT_WIDTH(16)) u_dut16 (.PCLK(PCLK), .PRESETn(rst_n), .bus(b16.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flag behaviour straight from the event rules, using integer arithmetic at width w
    function automatic logic [2:0] model_next(
        input int w, input logic [2:0] flg, input bit vld,
        input logic en, input logic down, input logic load,
        input longint unsigned prev, input longint unsigned cur, input longint unsigned cmp,
        input logic [2:0] clr);
        longint unsigned top;
        logic [2:0] ev;
        top = (64'd1 << w) - 64'd1;
        ev  = 3'b000;
        if (vld && en && !load) begin
            if (!down && prev == top && cur == 0)  ev[0] = 1'b1;
            if (down && prev == 0 && cur == top)   ev[1] = 1'b1;
            if (CMP_BUILT && cur == cmp && prev != cmp) ev[2] = 1'b1;
        end
        return ((flg & ~(clr & FLG_MASK)) | ev) & FLG_MASK;
    endfunction

    longint unsigned m_prev8 = 0, m_prev16 = 0;
    bit              m_vld8 = 0,  m_vld16 = 0;
    logic [2:0]      m_flg8 = 0,  m_flg16 = 0;

    always @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            m_prev8 <= 0; m_vld8 <= 0; m_flg8 <= 0;
            m_prev16 <= 0; m_vld16 <= 0; m_flg16 <= 0;
        end else begin
            m_flg8  <= model_next(8, m_flg8, m_vld8, b8.cnt_en, b8.cnt_down, b8.cnt_load,
                                  m_prev8, b8.cnt_value, b8.cmp_value, b8.flag_clr);
            m_flg16 <= model_next(16, m_flg16, m_vld16, b16.cnt_en, b16.cnt_down, b16.cnt_load,
                                  m_prev16, b16.cnt_value, b16.cmp_value, b16.flag_clr);
            m_prev8 <= b8.cnt_value;  m_vld8 <= 1;
            m_prev16 <= b16.cnt_value; m_vld16 <= 1;
        end
    end

    always @(negedge PCLK) begin
        check("m8_ovf", b8.tmr_ovf, m_flg8[0]);
        check("m8_udf", b8.tmr_udf, m_flg8[1]);
        check("m8_cmp", b8.tmr_cmp, m_flg8[2]);
        check("m8_irq", b8.tmr_irq, |(m_flg8 & b8.irq_en & FLG_MASK));
        check("m16_ovf", b16.tmr_ovf, m_flg16[0]);
        check("m16_udf", b16.tmr_udf, m_flg16[1]);
        check("m16_cmp", b16.tmr_cmp, m_flg16[2]);
        check("m16_irq", b16.tmr_irq, |(m_flg16 & b16.irq_en & FLG_MASK));
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_flags8(input string name, input logic ovf, input logic udf, input logic cmp);
        check({name, "_ovf"}, b8.tmr_ovf, ovf);
        check({name, "_udf"}, b8.tmr_udf, udf);
        check({name, "_cmp"}, b8.tmr_cmp, cmp);
    endtask

    initial begin
        b8.cnt_en = 1'b1;  b8.cnt_down = 1'b0;  b8.cnt_load = 1'b0;
        b8.cnt_value = 8'hFE; b8.cmp_value = 8'h40;
        b8.flag_clr = 3'b000; b8.irq_en = 3'b001;
        b16.cnt_en = 1'b1; b16.cnt_down = 1'b0; b16.cnt_load = 1'b0;
        b16.cnt_value = 16'hFFFE; b16.cmp_value = 16'h1234;
        b16.flag_clr = 3'b000; b16.irq_en = 3'b001;

        repeat (2) tick();
        check_flags8("rst", 1'b0, 1'b0, 1'b0);
        check("rst_irq", b8.tmr_irq, 1'b0);
        rst_n = 1'b1;

        // Overflow FE -> FF -> 00 (first edge after release cannot fire)
        tick();
        b8.cnt_value = 8'hFF; tick();
        check("ovf_pre", b8.tmr_ovf, 1'b0);
        b8.cnt_value = 8'h00; tick();
        check("ovf_set", b8.tmr_ovf, 1'b1);
        check("ovf_irq", b8.tmr_irq, 1'b1);
        b8.flag_clr = 3'b001; tick();
        b8.flag_clr = 3'b000;
        check("ovf_clr", b8.tmr_ovf, 1'b0);

        // Underflow 01 -> 00 -> FF
        b8.cnt_down = 1'b1;
        b8.cnt_value = 8'h01; tick();
        b8.cnt_value = 8'h00; tick();
        b8.cnt_value = 8'hFF; tick();
        check("udf_set", b8.tmr_udf, 1'b1);
        check("udf_irq_off", b8.tmr_irq, 1'b0);
        b8.irq_en = 3'b011; #1;
        check("udf_irq_on", b8.tmr_irq, 1'b1);
        b8.flag_clr = 3'b010; tick();
        b8.flag_clr = 3'b000;
        check("udf_clr", b8.tmr_udf, 1'b0);

        // Load jump 00 -> FF is not an underflow
        b8.cnt_value = 8'h00; tick();
        b8.cnt_load = 1'b1; b8.cnt_value = 8'hFF; tick();
        b8.cnt_load = 1'b0;
        check("load_noudf", b8.tmr_udf, 1'b0);

        // Wrap FF -> 00 while stopped, then re-enable: no event
        b8.cnt_down = 1'b0; tick();
        b8.cnt_en = 1'b0; b8.cnt_value = 8'h00; tick();
        check("dis_noovf", b8.tmr_ovf, 1'b0);
        b8.cnt_en = 1'b1; b8.cnt_value = 8'h01; tick();
        check("reen_noovf", b8.tmr_ovf, 1'b0);

        // Compare 3F -> 40 held
        b8.irq_en = 3'b100;
        b8.cnt_value = 8'h3F; tick();
        b8.cnt_value = 8'h40; tick();
        check("cmp_set", b8.tmr_cmp, CMP_BUILT);
        check("cmp_irq", b8.tmr_irq, CMP_BUILT);
        repeat (4) tick();
        check("cmp_hold", b8.tmr_cmp, CMP_BUILT);
        b8.flag_clr = 3'b100; tick();
        b8.flag_clr = 3'b000;
        check("cmp_clr", b8.tmr_cmp, 1'b0);
        repeat (3) tick();
        check("cmp_noreassert", b8.tmr_cmp, 1'b0);

        // Overflow and clear in the same cycle: set wins
        b8.cnt_value = 8'hFF; tick();
        b8.cnt_value = 8'h00; b8.flag_clr = 3'b001; tick();
        b8.flag_clr = 3'b000;
        check("ovf_setwins", b8.tmr_ovf, 1'b1);

        // Set underflow and compare together, then async reset mid-cycle
        b8.cnt_down = 1'b1; b8.cmp_value = 8'hFF; b8.cnt_value = 8'hFF; b8.irq_en = 3'b111; tick();
        check_flags8("all", 1'b1, 1'b1, CMP_BUILT);
        check("all_irq", b8.tmr_irq, 1'b1);
        #1;
        b8.cnt_down = 1'b0; b8.cnt_value = 8'h00;
        rst_n = 1'b0; #1;
        check_flags8("arst", 1'b0, 1'b0, 1'b0);
        check("arst_irq", b8.tmr_irq, 1'b0);
        check("arst_ovf16", b16.tmr_ovf, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        check("rel_noovf", b8.tmr_ovf, 1'b0);

        // Non-wrapping jumps (8-bit FF -> 05, 16-bit 00FF -> 0100), then 16-bit wrap
        b8.cnt_value = 8'hFF; b16.cnt_value = 16'h00FF; tick();
        b8.cnt_value = 8'h05; b16.cnt_value = 16'h0100; tick();
        check("jump_noovf8", b8.tmr_ovf, 1'b0);
        check("jump_noovf16", b16.tmr_ovf, 1'b0);
        b16.cnt_value = 16'hFFFF; tick();
        b16.cnt_value = 16'h0000; tick();
        check("ovf16_set", b16.tmr_ovf, 1'b1);
        check("ovf16_irq", b16.tmr_irq, 1'b1);

        // 16-bit compare match
        b16.cmp_value = 16'h0001; b16.cnt_value = 16'h0001; tick();
        check("cmp16", b16.tmr_cmp, CMP_BUILT);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
